// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue sitting between a variable-latency instruction
// memory and the IF stage of the 5-stage RISC-V pipeline. It walks fetch
// addresses sequentially, issues them to imem under a ready/valid handshake,
// and buffers the returned words in order together with their PCs so the
// IF/ID register can take one instruction per cycle. A redirect (branch,
// jal/jalr, trap or mret target) empties the buffer and arranges for every
// response still in flight to be thrown away when it returns.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//   NOP       word presented on o_inst while the queue is empty
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   o_imemReq      fetch request valid
//   o_imemAddr     fetch address (word aligned)
//   i_imemReady    imem accepts the request this cycle
//   i_imemRValid   read response valid (in request order)
//   i_imemRData    read response instruction word
//   i_redirect     load a new PC this cycle
//   i_redirectPC   redirect target (low two bits ignored)
//   i_stall        IF/ID is not accepting an instruction
//   o_instValid    head entry valid
//   o_inst         head instruction, NOP when empty
//   o_instPC       PC of the head instruction (0 when empty)
//   o_instPCPlus4  o_instPC + 4, modulo 2^32
//   o_empty        queue empty, used as a fetch-bubble stall
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0001_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemReady,
  input  logic        i_imemRValid,
  input  logic [31:0] i_imemRData,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPC,
  input  logic        i_stall,
  output logic        o_instValid,
  output logic [31:0] o_inst,
  output logic [31:0] o_instPC,
  output logic [31:0] o_instPCPlus4,
  output logic        o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DepthExt = (CW+1)'(DEPTH);

  logic [31:0]   fetchPC_q, fetchPC_d;
  logic [31:0]   respPC_q, respPC_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;

  logic [31:0]   instMem_q [DEPTH];
  logic [31:0]   pcMem_q   [DEPTH];

  logic [CW:0]   creditSum;
  logic          accept;
  logic          respKeep;
  logic          respDrop;
  logic          push;
  logic          pop;
  logic [31:0]   redirectAligned;

  // Handshake decode. A request is only offered when every word already
  // buffered plus every word still in flight leaves room for one more, so a
  // response can never find the queue full. Redirect overrides both push and
  // pop, and a response arriving while drop is nonzero belongs to a
  // superseded fetch stream.
  always_comb begin
    creditSum       = {1'b0, count_q} + {1'b0, outstanding_q};
    o_imemReq       = ~reset & ~i_redirect & (creditSum < DepthExt);
    o_imemAddr      = fetchPC_q;
    accept          = o_imemReq & i_imemReady;
    respKeep        = i_imemRValid & (drop_q == '0);
    respDrop        = i_imemRValid & (drop_q != '0);
    push            = respKeep & ~i_redirect;
    o_instValid     = (count_q != '0);
    o_empty         = ~o_instValid;
    pop             = o_instValid & ~i_stall & ~i_redirect;
    redirectAligned = {i_redirectPC[31:2], 2'b00};
  end

  // Head-of-queue presentation. The stored entry is only shown when valid;
  // an empty queue presents NOP with a zero PC so IF/ID sees a clean bubble.
  always_comb begin
    o_inst        = NOP;
    o_instPC      = '0;
    if (o_instValid) begin
      o_inst   = instMem_q[rdPtr_q];
      o_instPC = pcMem_q[rdPtr_q];
    end
    o_instPCPlus4 = o_instPC + 32'd4;
  end

  // Next-state logic for the control registers. outstanding tracks every
  // accepted request whose response has not yet come back, whether it will be
  // kept or dropped, so a redirect never clears it; instead drop is reloaded
  // with the number of responses still owed, minus one if a response is
  // consumed in the redirect cycle itself.
  always_comb begin
    fetchPC_d     = fetchPC_q;
    respPC_d      = respPC_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(i_imemRValid);
    drop_d        = drop_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;

    if (accept) begin
      fetchPC_d = fetchPC_q + 32'd4;
    end

    if (push) begin
      wrPtr_d  = wrPtr_q + AW'(1);
      respPC_d = respPC_q + 32'd4;
    end

    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (respDrop) begin
      drop_d = drop_q - CW'(1);
    end

    if (i_redirect) begin
      count_d   = '0;
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      fetchPC_d = redirectAligned;
      respPC_d  = redirectAligned;
      drop_d    = outstanding_q - CW'(i_imemRValid);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPC_q     <= RESET_PC;
      respPC_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
    end else begin
      fetchPC_q     <= fetchPC_d;
      respPC_q      <= respPC_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
    end
  end

  // Entry storage. No reset is needed: an entry is only ever read after a
  // push has written it, and the PC recorded is the one belonging to the
  // response, not the current fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      instMem_q[wrPtr_q] <= i_imemRData;
      pcMem_q[wrPtr_q]   <= respPC_q;
    end
  end

  // A response with nothing outstanding means the memory model and this
  // queue disagree about the request stream.
  respWithoutRequest : assert property (
    @(posedge clk) disable iff (reset) !(i_imemRValid && (outstanding_q == '0))
  );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Randomised bench for fetch_queue. A driver process plays the instruction
// memory and the pipeline (stall, redirect, reset); a monitor process keeps a
// transaction-level reference of the fetch stream and compares the DUT
// against it every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0001_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemReady;
  logic        i_imemRValid;
  logic [31:0] i_imemRData;
  logic        i_redirect;
  logic [31:0] i_redirectPC;
  logic        i_stall;
  logic        o_instValid;
  logic [31:0] o_inst;
  logic [31:0] o_instPC;
  logic [31:0] o_instPCPlus4;
  logic        o_empty;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .o_imemReq     (o_imemReq),
    .o_imemAddr    (o_imemAddr),
    .i_imemReady   (i_imemReady),
    .i_imemRValid  (i_imemRValid),
    .i_imemRData   (i_imemRData),
    .i_redirect    (i_redirect),
    .i_redirectPC  (i_redirectPC),
    .i_stall       (i_stall),
    .o_instValid   (o_instValid),
    .o_inst        (o_inst),
    .o_instPC      (o_instPC),
    .o_instPCPlus4 (o_instPCPlus4),
    .o_empty       (o_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pendT;

  // Requests accepted by the memory model and not yet answered, any epoch.
  pendT        pend[$];
  // PCs fetched in the current stream and not yet consumed by IF/ID.
  logic [31:0] sb[$];

  int          passCount = 0;
  int          totalCount = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          totalPops = 0;
  logic [31:0] refFetch = RESET_PC;
  logic        justReset = 1'b0;
  logic        prevStallReq = 1'b0;
  logic [31:0] prevAddr = '0;

  int          cfgStallPct = 0;
  int          cfgReadyPct = 100;
  int          cfgRedirPct = 0;
  int          cfgLatMin = 1;
  int          cfgLatMax = 1;
  logic        cfgReset = 1'b1;
  logic        redirPending = 1'b0;
  logic [31:0] redirTarget = '0;

  // Contents of the instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0] ^ 16'h5A3C, addr[31:16]} ^ 32'h0F0F_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int stallPct, input int readyPct, input int redirPct,
                               input int latMin, input int latMax, input int cycles);
    cfgStallPct = stallPct;
    cfgReadyPct = readyPct;
    cfgRedirPct = redirPct;
    cfgLatMin   = latMin;
    cfgLatMax   = latMax;
    repeat (cycles) @(posedge clk);
  endtask

  // Driver: memory model plus pipeline-side controls, updated just after
  // each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    reset        = cfgReset;
    i_stall      = ($urandom_range(0, 99) < cfgStallPct);
    i_imemReady  = ($urandom_range(0, 99) < cfgReadyPct);
    i_redirect   = 1'b0;
    i_redirectPC = $urandom();
    if (!cfgReset) begin
      if (redirPending) begin
        i_redirect   = 1'b1;
        i_redirectPC = redirTarget;
        redirPending = 1'b0;
      end else if ($urandom_range(0, 99) < cfgRedirPct) begin
        i_redirect   = 1'b1;
        i_redirectPC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom();
      end
    end
    i_imemRValid = 1'b0;
    i_imemRData  = $urandom();
    if (!cfgReset && pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        i_imemRValid = 1'b1;
        i_imemRData  = memWord(pend[0].addr);
      end
    end
  end

  // Monitor and reference model, evaluated mid-cycle while everything is
  // stable. Checks use the state at the start of the cycle, then the model
  // advances by what the coming rising edge will do.
  always @(negedge clk) begin
    logic expReq;
    pendT item;
    if (reset) begin
      checkOutput("reqInReset", 32'(o_imemReq), 32'd0);
      pend.delete();
      sb.delete();
      buffered     = 0;
      refFetch     = RESET_PC;
      epoch++;
      justReset    = 1'b1;
      prevStallReq = 1'b0;
    end else begin
      expReq = !i_redirect && ((buffered + pend.size()) < DEPTH);
      checkOutput("imemReq", 32'(o_imemReq), 32'(expReq));
      checkOutput("instValid", 32'(o_instValid), 32'(buffered > 0));
      checkOutput("empty", 32'(o_empty), 32'(buffered == 0));
      if (buffered == 0) begin
        checkOutput("nopWhenEmpty", o_inst, NOP);
      end
      if (justReset) begin
        checkOutput("pcAfterReset", o_instPC, 32'd0);
        checkOutput("pc4AfterReset", o_instPCPlus4, 32'd4);
        justReset = 1'b0;
      end
      if (prevStallReq && !i_redirect) begin
        checkOutput("addrStable", o_imemAddr, prevAddr);
      end

      if (buffered > 0 && sb.size() > 0) begin
        checkOutput("headPC", o_instPC, sb[0]);
        checkOutput("headInst", o_inst, memWord(sb[0]));
        checkOutput("headPC4", o_instPCPlus4, sb[0] + 32'd4);
      end

      if (o_imemReq && i_imemReady) begin
        checkOutput("imemAddr", o_imemAddr, refFetch);
        item.addr  = refFetch;
        item.due   = cyc + $urandom_range(cfgLatMin, cfgLatMax);
        item.epoch = epoch;
        pend.push_back(item);
        sb.push_back(refFetch);
        refFetch = refFetch + 32'd4;
      end

      if (i_imemRValid && pend.size() > 0) begin
        item = pend.pop_front();
        if (item.epoch == epoch && !i_redirect) begin
          buffered++;
        end
      end

      if (buffered > 0 && o_instValid && !i_stall && !i_redirect && sb.size() > 0) begin
        void'(sb.pop_front());
        buffered--;
        totalPops++;
      end

      if (i_redirect) begin
        epoch++;
        sb.delete();
        buffered = 0;
        refFetch = {i_redirectPC[31:2], 2'b00};
      end

      prevStallReq = o_imemReq && !i_imemReady;
      prevAddr     = o_imemAddr;
    end
  end

  initial begin
    reset        = 1'b1;
    i_imemReady  = 1'b0;
    i_imemRValid = 1'b0;
    i_imemRData  = '0;
    i_redirect   = 1'b0;
    i_redirectPC = '0;
    i_stall      = 1'b0;

    // Reset, then straight-line fetch with a 1-cycle memory.
    cfgReset = 1'b1;
    applyStimulus(0, 100, 0, 1, 1, 3);
    cfgReset = 1'b0;
    applyStimulus(0, 100, 0, 1, 1, 30);

    // Long IF/ID stall, then release.
    applyStimulus(100, 100, 0, 1, 1, 10);
    applyStimulus(0, 100, 0, 1, 1, 20);

    // 3-cycle memory, redirect to a misaligned target while responses fly.
    applyStimulus(0, 100, 0, 3, 3, 6);
    redirTarget  = 32'h0002_0002;
    redirPending = 1'b1;
    applyStimulus(0, 100, 0, 3, 3, 20);

    // Memory not ready: address holds, queue drains.
    applyStimulus(0, 0, 0, 1, 1, 8);
    applyStimulus(0, 100, 0, 1, 1, 10);

    // Address wrap at the top of memory.
    redirTarget  = 32'hFFFF_FFF4;
    redirPending = 1'b1;
    applyStimulus(0, 100, 0, 1, 1, 20);

    // Mixed random traffic.
    applyStimulus(30, 70, 5, 1, 4, 2000);

    // Reset in the middle of traffic, then carry on.
    cfgReset = 1'b1;
    applyStimulus(30, 70, 5, 1, 4, 2);
    cfgReset = 1'b0;
    applyStimulus(30, 70, 5, 1, 4, 500);

    @(negedge clk);
    checkOutput("progress", 32'(totalPops > 100), 32'd1);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue between a variable-latency instruction memory and the IF stage of the 5-stage RISC-V pipeline.
- Generates sequential fetch addresses, issues requests to imem under a ready/valid handshake, and buffers returned instructions in order with their PCs.
- Supplies the IF/ID register one instruction per cycle.
- On a redirect (branch, jal/jalr, trap or mret target) it flushes buffered instructions and discards in-flight responses.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 32'h0001_0000, first fetch address after reset.
- NOP, 32'h0000_0013, instruction driven on o_inst when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- o_imemReq  output  1  fetch request valid.
- o_imemAddr  output  32  fetch address; word aligned, [1:0] always 2'b00.
- i_imemReady  input  1  imem accepts the request this cycle.
- i_imemRValid  input  1  read response valid; responses return in request order, at least 1 cycle after acceptance.
- i_imemRData  input  32  response instruction word.
- i_redirect  input  1  take new PC this cycle (Ei_PCSrc != 0, or Di_jal).
- i_redirectPC  input  32  redirect target; bits [1:0] forced to 0 internally.
- i_stall  input  1  IF/ID not accepting (Fi_stall).
- o_instValid  output  1  head entry valid.
- o_inst  output  32  head instruction, or NOP when empty.
- o_instPC  output  32  PC of the head instruction.
- o_instPCPlus4  output  32  o_instPC + 4, modulo 2^32.
- o_empty  output  1  queue empty; hazard unit uses it as a fetch-bubble stall.

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk.
- Reset (synchronous, highest priority) sets:
  - fetchPC = RESET_PC;
  - count = 0, outstanding = 0, drop = 0;
  - read and write pointers = 0.
- Outputs in the cycle after reset:
  - o_imemReq = 0 in the reset cycle itself, 1 in the first cycle after;
  - o_instValid = 0, o_inst = NOP, o_instPC = 0, o_instPCPlus4 = 4, o_empty = 1.
- Credit rule:
  - o_imemReq = ~reset & ~i_redirect & ((count + outstanding) < DEPTH).
  - This guarantees every returned response has a free slot, so no overflow is possible.
- Issue:
  - A request is accepted when o_imemReq & i_imemReady.
  - On acceptance: outstanding increments and fetchPC += 4 (wraps at 2^32). o_imemAddr = fetchPC.
  - o_imemReq and o_imemAddr stay stable while i_imemReady = 0, unless a redirect occurs.
- Response:
  - On i_imemRValid with drop = 0: push {i_imemRData, PC} into the queue and decrement outstanding.
  - The stored PC comes from an internal respPC register, set to the redirect target (or RESET_PC) and advanced by 4 on each accepted push.
  - On i_imemRValid with drop > 0: discard the data, decrement drop and outstanding.
- Pop:
  - Occurs when o_instValid & ~i_stall; the read pointer advances.
  - Push and pop in the same cycle leave count unchanged. This includes count = DEPTH-1 and count = 1.
  - When count = 0, a push makes the entry visible the next cycle. There is no combinational bypass.
- Outputs:
  - o_instValid = (count != 0); o_empty = ~o_instValid.
  - o_inst = head data when valid, else NOP; o_instPC = head PC.
- Redirect (i_redirect = 1) overrides push and pop in the same cycle:
  - count = 0, pointers = 0;
  - fetchPC = respPC = {i_redirectPC[31:2], 2'b00};
  - drop = outstanding minus 1 if a response arrives in that same cycle (that response is discarded), otherwise drop = outstanding;
  - no request is issued in the redirect cycle;
  - fetch resumes the next cycle.
- Back-to-back redirects: each redirect overwrites the previous one. drop accumulates correctly because outstanding is never cleared by a redirect.
- Counters:
  - count, outstanding and drop are log2(DEPTH)+1 bits wide.
  - outstanding <= DEPTH holds by construction.
  - Assertion: i_imemRValid never arrives while outstanding = 0.

Test Plan:
- Reset, imem with ready=1 and 1-cycle latency, i_stall=0 -> addresses 0x10000, 0x10004, 0x10008… issued; first o_instValid 2 cycles after reset release; o_instPC 0x10000, then +4 every cycle; o_instPCPlus4 = 0x10004.
- Hold i_stall=1 for 10 cycles -> at most 4 requests outstanding or buffered; o_imemReq drops to 0; on release, instructions emerge in order with no loss or duplication.
- Imem latency 3 cycles, redirect to 0x20002 while 2 responses are in flight -> both stale responses discarded; next o_instPC = 0x20000 and o_inst = mem[0x20000].
- Redirect asserted in the same cycle as i_imemRValid and a pop -> the response is discarded, count = 0, no request issued that cycle, request to the target the next cycle.
- i_imemReady held 0 for 5 cycles -> o_imemAddr stable; queue drains to empty; o_inst = 0x00000013, o_empty = 1.
- fetchPC = 0xFFFFFFFC -> next request address 0x00000000; o_instPCPlus4 of that entry = 0x00000000.
- Reset asserted mid-stream with responses outstanding -> all state cleared; fetch restarts at RESET_PC; a late response arriving after reset triggers the assertion, and the bench must not send one.
